// File: rtl/flow_timeout_scanner.sv
// flow_timeout_scanner: periodic flow-table aging walker that issues one expire request per timed-out entry.
// Optional hard-timeout support is compiled in by defining FLOW_TIMEOUT_HARD_EN.
// Trigger to first read is 1 cycle; 2 cycles per entry; an expire holds until expire_ready.
module flow_timeout_scanner #(
  parameter int ENTRY_NUM      = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TS_WIDTH       = 8,
  parameter int SCAN_PERIOD_MS = 100
) (
  input  logic                  asclk,
  input  logic                  aresetn,
  input  logic [TS_WIDTH-1:0]   s_counter,
  input  logic                  ms_pulse,
  input  logic                  scan_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
`ifdef FLOW_TIMEOUT_HARD_EN
  input  logic [4*TS_WIDTH:0]   mem_rd_data,
`else
  input  logic [2*TS_WIDTH:0]   mem_rd_data,
`endif
  input  logic                  upd_wr_en,
  input  logic [ADDR_WIDTH-1:0] upd_wr_addr,
  output logic                  expire_valid,
  output logic [ADDR_WIDTH-1:0] expire_addr,
  input  logic                  expire_ready,
`ifdef FLOW_TIMEOUT_HARD_EN
  output logic                  expire_hard,
`endif
  output logic                  scan_busy,
  output logic [15:0]           scan_overrun
);

`ifdef FLOW_TIMEOUT_HARD_EN
  localparam int DW = 1 + 4*TS_WIDTH;
`else
  localparam int DW = 1 + 2*TS_WIDTH;
`endif
  localparam int PCW = 10;
  localparam logic [PCW-1:0]        PER_LAST  = PCW'(SCAN_PERIOD_MS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ENTRY_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP, S_EXP} state_t;

  state_t                state_q, state_d;
  logic [PCW-1:0]        per_q, per_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pending_q, pending_d;
  logic                  hz_q, hz_d;
  logic [15:0]           ovr_q, ovr_d;
  logic                  hard_q, hard_d;

  // Entry fields as returned by the stats memory in the CMP cycle
  logic                ent_valid;
  logic [TS_WIDTH-1:0] last_seen, idle_to, idle_el;
  logic                idle_hit, hard_hit;

  assign ent_valid = mem_rd_data[DW-1];
  assign last_seen = mem_rd_data[TS_WIDTH-1:0];
  assign idle_to   = mem_rd_data[2*TS_WIDTH-1:TS_WIDTH];
  // Modular subtraction keeps the age correct across seconds-counter wrap
  assign idle_el   = s_counter - last_seen;
  assign idle_hit  = ent_valid && (idle_to != '0) && (idle_el >= idle_to);

`ifdef FLOW_TIMEOUT_HARD_EN
  logic [TS_WIDTH-1:0] install_ts, hard_to, hard_el;
  assign install_ts = mem_rd_data[3*TS_WIDTH-1:2*TS_WIDTH];
  assign hard_to    = mem_rd_data[4*TS_WIDTH-1:3*TS_WIDTH];
  assign hard_el    = s_counter - install_ts;
  assign hard_hit   = ent_valid && (hard_to != '0) && (hard_el >= hard_to);
`else
  assign hard_hit   = 1'b0;
`endif

  logic upd_hit, exp_now, last_entry, trigger, start;

  // A lookup-path write to the entry under test means it was just seen; skip it this pass
  assign upd_hit    = upd_wr_en && (upd_wr_addr == addr_q);
  assign exp_now    = (idle_hit || hard_hit) && !(hz_q || upd_hit);
  assign last_entry = (addr_q == ADDR_LAST);
  assign trigger    = ms_pulse && (per_q == PER_LAST) && scan_en;
  assign start      = (state_q == S_IDLE) && (trigger || pending_q);

  // State and datapath registers
  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      per_q     <= '0;
      addr_q    <= '0;
      pending_q <= 1'b0;
      hz_q      <= 1'b0;
      ovr_q     <= '0;
      hard_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      hz_q      <= hz_d;
      ovr_q     <= ovr_d;
      hard_q    <= hard_d;
    end
  end

  // Next-state logic of the walker
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trigger || pending_q) state_d = S_RD;
      S_RD:    state_d = S_CMP;
      S_CMP:   if (exp_now) state_d = S_EXP;
               else         state_d = last_entry ? S_IDLE : S_RD;
      S_EXP:   if (expire_ready) state_d = last_entry ? S_IDLE : S_RD;
      default: state_d = S_IDLE;
    endcase
  end

  // Period counter, entry address, pending/overrun bookkeeping and per-entry flags
  always_comb begin
    per_d     = per_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    hz_d      = hz_q;
    ovr_d     = ovr_q;
    hard_d    = hard_q;
    if (ms_pulse) per_d = (per_q == PER_LAST) ? '0 : per_q + PCW'(1);
    if (start) begin
      addr_d    = '0;
      pending_d = 1'b0;
    end else if (trigger && (state_q != S_IDLE)) begin
      if (!pending_q)            pending_d = 1'b1;
      else if (ovr_q != 16'hFFFF) ovr_d    = ovr_q + 16'd1;
    end
    // Disabling scans discards a queued start; the running scan still completes
    if (!scan_en) pending_d = 1'b0;
    if (state_q == S_RD) hz_d = upd_hit;
    if (state_q == S_CMP) begin
      hard_d = hard_hit && exp_now;
      if (!exp_now && !last_entry) addr_d = addr_q + ADDR_WIDTH'(1);
    end
    if ((state_q == S_EXP) && expire_ready && !last_entry) addr_d = addr_q + ADDR_WIDTH'(1);
  end

  // Outputs decoded from the current state
  always_comb begin
    mem_rd_en    = (state_q == S_RD);
    mem_rd_addr  = addr_q;
    expire_valid = (state_q == S_EXP);
    expire_addr  = (state_q == S_EXP) ? addr_q : '0;
    scan_busy    = (state_q != S_IDLE);
    scan_overrun = ovr_q;
`ifdef FLOW_TIMEOUT_HARD_EN
    expire_hard  = (state_q == S_EXP) && hard_q;
`endif
  end

`ifndef FLOW_TIMEOUT_HARD_EN
  logic unused_hard;
  assign unused_hard = hard_q;
`endif

endmodule

// File: tb/tb_flow_timeout_scanner.sv
// Scoreboard bench for flow_timeout_scanner: a table model predicts expires, a monitor pops and compares.
module tb_flow_timeout_scanner;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int TS = 8;
  localparam int P  = 4;
`ifdef FLOW_TIMEOUT_HARD_EN
  localparam int DW = 1 + 4*TS;
`else
  localparam int DW = 1 + 2*TS;
`endif

  logic          asclk, aresetn, ms_pulse, scan_en, mem_rd_en, upd_wr_en;
  logic          expire_valid, expire_ready, scan_busy;
  logic [TS-1:0] s_counter;
  logic [AW-1:0] mem_rd_addr, upd_wr_addr, expire_addr;
  logic [DW-1:0] mem_rd_data;
  logic [15:0]   scan_overrun;
`ifdef FLOW_TIMEOUT_HARD_EN
  logic          expire_hard;
`endif

  flow_timeout_scanner #(.ENTRY_NUM(N), .ADDR_WIDTH(AW), .TS_WIDTH(TS), .SCAN_PERIOD_MS(P)) dut (
    .asclk(asclk), .aresetn(aresetn), .s_counter(s_counter), .ms_pulse(ms_pulse), .scan_en(scan_en),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .upd_wr_en(upd_wr_en), .upd_wr_addr(upd_wr_addr),
    .expire_valid(expire_valid), .expire_addr(expire_addr), .expire_ready(expire_ready),
`ifdef FLOW_TIMEOUT_HARD_EN
    .expire_hard(expire_hard),
`endif
    .scan_busy(scan_busy), .scan_overrun(scan_overrun)
  );

  initial begin
    asclk = 0;
    forever #5 asclk = ~asclk;
  end

  // Flow table contents
  logic          mem_v    [N];
  logic [TS-1:0] mem_idle [N];
  logic [TS-1:0] mem_ls   [N];
  logic [TS-1:0] mem_hto  [N];
  logic [TS-1:0] mem_ins  [N];

  // Stats memory: registered read, data valid the cycle after the strobe
  always @(posedge asclk) begin
    if (mem_rd_en) begin
`ifdef FLOW_TIMEOUT_HARD_EN
      mem_rd_data <= {mem_v[mem_rd_addr], mem_hto[mem_rd_addr], mem_ins[mem_rd_addr],
                      mem_idle[mem_rd_addr], mem_ls[mem_rd_addr]};
`else
      mem_rd_data <= {mem_v[mem_rd_addr], mem_idle[mem_rd_addr], mem_ls[mem_rd_addr]};
`endif
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  typedef struct { int addr; bit hard; } exp_t;
  exp_t exp_q[$];

  // Reference rule: age in seconds modulo the timestamp range, compared against the timeout
  function automatic bit model_expired(input int i, input int s, output bit hard);
    int el, hel;
    bit idle_x, hard_x;
    el     = (s - int'(mem_ls[i]) + (1 << TS)) % (1 << TS);
    idle_x = mem_v[i] && (mem_idle[i] != 0) && (el >= int'(mem_idle[i]));
    hard_x = 0;
`ifdef FLOW_TIMEOUT_HARD_EN
    hel    = (s - int'(mem_ins[i]) + (1 << TS)) % (1 << TS);
    hard_x = mem_v[i] && (mem_hto[i] != 0) && (hel >= int'(mem_hto[i]));
`else
    hel    = 0;
`endif
    hard = hard_x;
    return idle_x || hard_x;
  endfunction

  // expire_ready driver: 0 always ready, 1 random, 2 stall N cycles once, 3 never ready
  int rdy_mode = 0;
  int stall_left = 0;
  initial begin
    expire_ready = 1;
    forever begin
      @(posedge asclk); #1;
      case (rdy_mode)
        1: expire_ready = ($urandom_range(0, 99) < 60);
        2: begin
          if (expire_valid && stall_left > 0) begin
            expire_ready = 0;
            stall_left--;
          end else expire_ready = 1;
        end
        3: expire_ready = 0;
        default: expire_ready = 1;
      endcase
    end
  end

  // Lookup-path writes: a targeted hit on hz_addr (RD or CMP cycle), plus noise to other entries
  int hz_addr = -1;
  bit hz_in_cmp = 0;
  bit hz_next = 0;
  initial begin
    upd_wr_en = 0;
    upd_wr_addr = '0;
    forever begin
      @(posedge asclk); #1;
      upd_wr_en = 0;
      if (hz_next) begin
        upd_wr_en = 1;
        upd_wr_addr = AW'(hz_addr);
        hz_next = 0;
      end else if (mem_rd_en && int'(mem_rd_addr) == hz_addr) begin
        if (hz_in_cmp) hz_next = 1;
        else begin
          upd_wr_en = 1;
          upd_wr_addr = mem_rd_addr;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        upd_wr_en = 1;
        upd_wr_addr = mem_rd_addr + AW'($urandom_range(1, N - 1));
      end
    end
  end

  // Monitor: read sequence, expire scoreboard, handshake stability, scan length
  int rd_idx = 0;
  int busy_len = 0;
  int evld = 0;
  bit prev_busy = 0;
  bit prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  exp_t mon_e;
  always @(negedge asclk) begin
    if (!aresetn) begin
      rd_idx = 0; busy_len = 0; evld = 0; prev_busy = 0; prev_stall = 0;
    end else begin
      if (prev_stall) check("expire_stable", {expire_valid, expire_addr}, {1'b1, prev_addr});
      if (mem_rd_en) begin
        check("rd_addr", mem_rd_addr, rd_idx);
        rd_idx++;
      end
      if (expire_valid && expire_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL expire_extra: got addr %0d, expected no expire", expire_addr);
        end else begin
          mon_e = exp_q.pop_front();
          check("expire_addr", expire_addr, mon_e.addr);
`ifdef FLOW_TIMEOUT_HARD_EN
          check("expire_hard", expire_hard, mon_e.hard);
`endif
        end
      end
      if (scan_busy) begin
        busy_len++;
        if (expire_valid) evld++;
      end
      if (prev_busy && !scan_busy) begin
        check("rd_count", rd_idx, N);
        check("scan_len", busy_len, 2*N + evld);
        rd_idx = 0; busy_len = 0; evld = 0;
      end
      prev_busy  = scan_busy;
      prev_stall = expire_valid && !expire_ready;
      prev_addr  = expire_addr;
    end
  end

  int ms_model = 0;

  task automatic pulse(output bit trig);
    trig = scan_en && (ms_model == P - 1);
    ms_model = (ms_model + 1) % P;
    @(posedge asclk); #1 ms_pulse = 1;
    @(posedge asclk); #1 ms_pulse = 0;
    @(negedge asclk);
  endtask

  task automatic pulses(input int n);
    bit t;
    repeat (n) pulse(t);
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      mem_v[i] = 0; mem_idle[i] = 0; mem_ls[i] = 0; mem_hto[i] = 0; mem_ins[i] = 0;
    end
  endtask

  task automatic set_entry(input int i, input bit v, input int idle, input int ls, input int hto, input int ins);
    mem_v[i] = v; mem_idle[i] = TS'(idle); mem_ls[i] = TS'(ls); mem_hto[i] = TS'(hto); mem_ins[i] = TS'(ins);
  endtask

  task automatic push_expected(input int s, input int hz);
    bit h;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (model_expired(i, s, h) && i != hz) begin
        e.addr = i; e.hard = h;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic trigger_scan();
    bit t;
    int k;
    t = 0; k = 0;
    while (!t && k <= P) begin pulse(t); k++; end
    check("scan_start_busy", scan_busy, 1);
    check("scan_start_rd", {mem_rd_en, mem_rd_addr}, {1'b1, {AW{1'b0}}});
  endtask

  task automatic finish_scan(output int len);
    int k;
    len = 1; k = 0;
    while (scan_busy && k < 3000) begin
      @(negedge asclk);
      if (scan_busy) len++;
      k++;
    end
    check("scan_end", scan_busy, 0);
    check("exp_queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_scan(input int s, input int hz, input bit in_cmp, output int len);
    s_counter = TS'(s);
    hz_addr = hz;
    hz_in_cmp = in_cmp;
    push_expected(s, hz);
    trigger_scan();
    finish_scan(len);
    hz_addr = -1;
  endtask

  task automatic wait_expire();
    int w;
    w = 0;
    while (!expire_valid && w < 200) begin @(negedge asclk); w++; end
    check("expire_seen", expire_valid, 1);
  endtask

  initial begin
    int len, seen, s;
    bit t;
    aresetn = 0; ms_pulse = 0; scan_en = 0; s_counter = '0;
    clear_table();
    repeat (3) @(posedge asclk);
    @(negedge asclk);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_expire_valid", expire_valid, 0);
    check("rst_expire_addr", expire_addr, 0);
    check("rst_scan_busy", scan_busy, 0);
    check("rst_scan_overrun", scan_overrun, 0);
    @(posedge asclk); #1 aresetn = 1;
    @(negedge asclk);

    // Periodic trigger, empty table: busy only after the 4th pulse, full 64-cycle walk
    scan_en = 1;
    for (int k = 0; k < P - 1; k++) begin
      pulse(t);
      check("no_early_busy", scan_busy, 0);
    end
    trigger_scan();
    finish_scan(len);
    check("empty_scan_len", len, 2*N);

    // Idle expiry across timestamp wrap, and one second short of it
    set_entry(5, 1, 10, 250, 0, 0);
    run_scan(4, -1, 0, len);
    check("wrap_expire_len", len, 2*N + 1);
    run_scan(3, -1, 0, len);
    check("wrap_noexp_len", len, 2*N);

    // Backpressure: two expires, the first stalled 7 cycles
    clear_table();
    set_entry(2, 1, 5, 0, 0, 0);
    set_entry(3, 1, 5, 0, 0, 0);
    rdy_mode = 2; stall_left = 7;
    run_scan(10, -1, 0, len);
    check("backpressure_len", len, 2*N + 7 + 2);
    rdy_mode = 0;

    // Write hazard in CMP and in RD suppresses the expire; a clean pass then expires it
    clear_table();
    set_entry(9, 1, 20, 100, 0, 0);
    run_scan(130, 9, 1, len);
    check("hazard_cmp_len", len, 2*N);
    run_scan(130, 9, 0, len);
    check("hazard_rd_len", len, 2*N);
    run_scan(130, -1, 0, len);
    check("hazard_clear_len", len, 2*N + 1);

`ifdef FLOW_TIMEOUT_HARD_EN
    // Hard-only, idle-only and both
    clear_table();
    set_entry(7, 1, 0, 0, 3, 0);
    set_entry(8, 1, 2, 0, 0, 0);
    set_entry(10, 1, 1, 0, 2, 0);
    run_scan(3, -1, 0, len);
`endif

    // Random tables clustered around the timeout boundary, random backpressure and hazards
    rdy_mode = 1;
    for (int r = 0; r < 20; r++) begin
      s = $urandom_range(0, 255);
      for (int i = 0; i < N; i++) begin
        mem_v[i]    = 1'($urandom_range(0, 1));
        mem_idle[i] = ($urandom_range(0, 4) == 0) ? '0 : TS'($urandom_range(1, 255));
        mem_ls[i]   = TS'(s - int'(mem_idle[i]) + $urandom_range(0, 4) - 2);
        mem_hto[i]  = ($urandom_range(0, 1) == 0) ? '0 : TS'($urandom_range(1, 255));
        mem_ins[i]  = TS'(s - int'(mem_hto[i]) + $urandom_range(0, 4) - 2);
      end
      run_scan(s, ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1,
               1'($urandom_range(0, 1)), len);
    end
    rdy_mode = 0;

    // Overrun: scan stuck in EXP, first extra trigger pends, later ones count
    clear_table();
    set_entry(0, 1, 1, 0, 0, 0);
    s_counter = TS'(5);
    rdy_mode = 3;
    trigger_scan();
    wait_expire();
    check("stuck_expire_addr", expire_addr, 0);
    pulses(P);
    check("overrun_after_pending", scan_overrun, 0);
    pulses(P);
    check("overrun_one", scan_overrun, 1);
    pulses(P);
    check("overrun_two", scan_overrun, 2);

    // Reset mid-EXP clears everything on the next cycle; nothing restarts afterwards
    @(posedge asclk); #1 aresetn = 0;
    @(posedge asclk);
    @(negedge asclk);
    check("rst_exp_valid", expire_valid, 0);
    check("rst_exp_busy", scan_busy, 0);
    check("rst_exp_overrun", scan_overrun, 0);
    check("rst_exp_rd", {mem_rd_en, mem_rd_addr, expire_addr}, 0);
    @(posedge asclk); #1 aresetn = 1;
    exp_q.delete();
    ms_model = 0;
    rdy_mode = 0;
    seen = 0;
    repeat (6) begin @(negedge asclk); seen = seen | int'(scan_busy); end
    check("no_restart_after_reset", seen, 0);

    // Disabling scans mid-scan lets it finish but drops the pending start
    rdy_mode = 3;
    push_expected(5, -1);
    trigger_scan();
    wait_expire();
    pulses(P);
    scan_en = 0;
    @(negedge asclk);
    rdy_mode = 0;
    finish_scan(len);
    scan_en = 1;
    seen = 0;
    repeat (6) begin @(negedge asclk); seen = seen | int'(scan_busy); end
    check("pending_dropped", seen, 0);

    // Recovery scan after all of the above
    run_scan(5, -1, 0, len);
    check("recovery_len", len, 2*N + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flow_timeout_scanner.md
# flow_timeout_scanner

Periodic aging controller for the OpenFlow datapath flow table. On a programmable millisecond cadence it walks every flow entry and reads each entry's valid bit, idle timeout and last-seen timestamp. It compares the elapsed time against the seconds time base and issues one expire request per timed-out entry to the table-management logic. It sits between the us/ms/s time-base counter and the flow-table statistics memory, and it sequences that memory's read port.

## Interface
Reset is `aresetn`: synchronous, active-low. Clock is `asclk`.

Parameters:
- `ENTRY_NUM`, default 32: number of flow entries; must be a power of two.
- `ADDR_WIDTH`, default 5: log2(`ENTRY_NUM`).
- `TS_WIDTH`, default 8: width of the seconds timestamp and of the timeout fields.
- `SCAN_PERIOD_MS`, default 100: number of `ms_pulse` events between scan starts; range 1..1023.

Ports:
- `asclk`  in  1  clock
- `aresetn`  in  1  synchronous active-low reset
- `s_counter`  in  TS_WIDTH  current seconds value from the time base
- `ms_pulse`  in  1  one-cycle pulse, once per millisecond
- `scan_en`  in  1  enables periodic scans
- `mem_rd_en`  out  1  read strobe to the stats memory
- `mem_rd_addr`  out  ADDR_WIDTH  read address
- `mem_rd_data`  in  1+2*TS_WIDTH  read data {valid, idle_to, last_seen}; valid the cycle after `mem_rd_en`
- `upd_wr_en`  in  1  lookup path writing `last_seen` (snooped only)
- `upd_wr_addr`  in  ADDR_WIDTH  lookup path write address
- `expire_valid`  out  1  expire request
- `expire_addr`  out  ADDR_WIDTH  entry to expire
- `expire_ready`  in  1  expire accepted
- `scan_busy`  out  1  high while a scan is in progress
- `scan_overrun`  out  16  saturating count of scan starts that were dropped

## Operation
- Period counter counts `ms_pulse` events. A trigger fires when the count reaches SCAN_PERIOD_MS-1 and `ms_pulse` is high; the counter then wraps to 0. The counter runs even when `scan_en`=0, but a trigger is taken only when `scan_en`=1.
- FSM states:
  - IDLE: on a trigger or `pending`, go to RD with addr=0 and clear `pending`.
  - RD: assert `mem_rd_en` with `mem_rd_addr`=addr; go to CMP.
  - CMP: evaluate `mem_rd_data`. If expired, go to EXP. Otherwise, if addr=ENTRY_NUM-1 go to IDLE, else addr+1 and go to RD.
  - EXP: hold `expire_valid` and `expire_addr` until `expire_ready`, then advance exactly as CMP does.
- elapsed = (`s_counter` − `last_seen`) mod 2^TS_WIDTH (wrap-safe).
- An entry is expired when valid=1, idle_to≠0 and elapsed ≥ idle_to.
- Write hazard: if `upd_wr_en` is high with `upd_wr_addr`=addr during the RD or CMP cycle of that entry, the entry is not expired in this scan.
- Trigger while busy: set the 1-deep `pending` flag. If `pending` is already set, drop the trigger and increment `scan_overrun` (saturating at 0xFFFF).
- `scan_en` falling mid-scan: the current scan completes, and `pending` is cleared.

## Timing
- Reset values:
  - outputs: `mem_rd_en`=0, `mem_rd_addr`=0, `expire_valid`=0, `expire_addr`=0, `scan_busy`=0, `scan_overrun`=0.
  - internal: period count=0, `pending`=0, FSM=IDLE.
- The first scan starts SCAN_PERIOD_MS pulses after reset.
- Trigger to first `mem_rd_en`: 1 cycle.
- Each entry takes 2 cycles (RD, CMP), plus 1 cycle for an expire accepted immediately, plus 1 cycle per extra `expire_ready`-low cycle.
- Minimum full scan is 2·ENTRY_NUM cycles.
- `scan_busy` is high from the first RD through the final CMP or EXP.
- `expire_valid` is stable while `expire_ready` is low. The handshake completes on the cycle both are high.
- Reset mid-scan aborts immediately, including deasserting `expire_valid`; no pending state survives.

## Configuration
- `FLOW_TIMEOUT_HARD_EN` defined:
  - `mem_rd_data` becomes {valid, hard_to, install_ts, idle_to, last_seen}, 1+4*TS_WIDTH bits.
  - An entry is also expired when hard_to≠0 and (`s_counter`−install_ts) mod 2^TS_WIDTH ≥ hard_to.
  - Extra output `expire_hard` (1 bit, reset 0), valid with `expire_valid`: 1 when the hard condition hit, 0 for idle only. If both conditions hold, `expire_hard`=1.
- `FLOW_TIMEOUT_HARD_EN` undefined: idle timeout only, no `expire_hard` port, narrow `mem_rd_data`.

## Test plan
- Periodic trigger: SCAN_PERIOD_MS=4, all entries invalid, continuous `ms_pulse` -> `scan_busy` rises after the 4th pulse; 32 `mem_rd_en` strobes at addr 0..31 over 64 cycles; no `expire_valid`.
- Idle expiry with wrap: entry 5 has valid=1, idle_to=10, last_seen=250, `s_counter`=4 (elapsed 10) -> exactly one expire with `expire_addr`=5. The same entry with `s_counter`=3 -> no expire.
- Backpressure: entries 2 and 3 expired, `expire_ready` held low 7 cycles -> `expire_valid`/`expire_addr`=2 held stable 7 cycles, then addr 3 issued; scan length is 64+7+2 cycles.
- Write hazard: expired entry 9, `upd_wr_en` with `upd_wr_addr`=9 during its CMP cycle -> no expire for 9 this scan. The next scan, with no write, expires 9.
- Overrun: SCAN_PERIOD_MS=1, `expire_ready`=0 with one expired entry -> `pending` sets, then `scan_overrun` increments once per further pulse. Reset mid-EXP -> all outputs return to 0 on the next cycle.
- With `FLOW_TIMEOUT_HARD_EN`: hard_to=3, install_ts=0, `s_counter`=3, idle not expired -> expire with `expire_hard`=1.
